// File: rtl/mdu_pkg.sv
// Shared op codes and divider FSM encoding for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step, MSB first.
// The sequencing (load/step) comes from the owning FSM; last flags the final step.
module div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // The extra top bit of diff is the borrow: set means the trial subtract failed.
  always_comb begin
    rem_sh = {rem_q, quot_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvsr_q <= divisor;
      cnt_q  <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
      if (!diff[WIDTH]) begin
        rem_q  <= diff[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q  <= rem_sh[WIDTH-1:0];
        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign last      = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit owning HI/LO: single-cycle multiply and accumulate,
// iterative signed/unsigned divide that stalls the pipeline while running.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] mul_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               is_sdiv;
  logic               accept_div;
  logic               run_step;
  logic               last;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;

  // Products are formed at full width so the low 2*WIDTH bits are exact for both signednesses.
  always_comb begin
    prod_s     = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    acc        = {hi, lo};
    is_div     = (op == OP_DIV) || (op == OP_DIVU);
    is_sdiv    = (op == OP_DIV);
    a_abs      = (is_sdiv && a[WIDTH-1]) ? -a : a;
    b_abs      = (is_sdiv && b[WIDTH-1]) ? -b : b;
    accept_div = (state == IDLE) && start && is_div && (b != '0);
    run_step   = (state == RUN);
    stall      = accept_div || (state == RUN);
  end

  assign mul_result = prod_s;

  div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_div),
    .step      (run_step),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT:  {hi, lo} <= prod_s;
              OP_MULTU: {hi, lo} <= prod_u;
              OP_MADD:  {hi, lo} <= acc + prod_s;
              OP_MADDU: {hi, lo} <= acc + prod_u;
              OP_MSUB:  {hi, lo} <= acc - prod_s;
              OP_MSUBU: {hi, lo} <= acc - prod_u;
              OP_MTHI:  hi <= a;
              OP_MTLO:  lo <= a;
              OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  q_neg <= is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg <= is_sdiv && a[WIDTH-1];
                  state <= RUN;
                  busy  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (last) state <= FIX;
        end
        FIX: begin
          lo    <= q_neg ? -quotient : quotient;
          hi    <= r_neg ? -remainder : remainder;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, divide corner
// sequences, and random ops checked against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
  import mdu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [63:0] mul_result;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_by_zero;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] mul8;
  logic [7:0]  hi8, lo8;
  logic        busy8, stall8, done8, dbz8;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi, m_lo;
  vec_t        vecs[10];

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mul_result(mul_result), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done), .div_by_zero(div_by_zero)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .mul_result(mul8), .hi(hi8), .lo(lo8), .busy(busy8),
    .stall(stall8), .done(done8), .div_by_zero(dbz8)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // HI/LO behaviour expressed directly as 64-bit arithmetic on the architectural pair.
  task automatic model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] pair, ps, pu;
    longint      sx, sy, q, r;
    pair = {m_hi, m_lo};
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ps   = sx * sy;
    pu   = {32'd0, x} * {32'd0, y};
    case (o)
      OP_MULT:  pair = ps;
      OP_MULTU: pair = pu;
      OP_MADD:  pair = pair + ps;
      OP_MADDU: pair = pair + pu;
      OP_MSUB:  pair = pair - ps;
      OP_MSUBU: pair = pair - pu;
      OP_MTHI:  pair[63:32] = x;
      OP_MTLO:  pair[31:0] = x;
      OP_DIV: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        pair = {r[31:0], q[31:0]};
      end
      OP_DIVU: if (y != 0) begin
        q = longint'({32'd0, x}) / longint'({32'd0, y});
        r = longint'({32'd0, x}) % longint'({32'd0, y});
        pair = {r[31:0], q[31:0]};
      end
      default: ;
    endcase
    {m_hi, m_lo} = pair;
  endtask

  // Single-cycle op on the 32-bit unit; called at a falling edge, returns at the next one.
  task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    p = longint'($signed(x)) * longint'($signed(y));
    check_output("mul_result", mul_result, p);
    check_output("stall_single", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    model_apply(o, x, y);
  endtask

  task automatic run_div32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int edges, stalls;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check_output("div_stall_accept", stall, y != 0);
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    model_apply(o, x, y);
    if (y == 0) begin
      check_output("dbz_done", done, 1'b1);
      check_output("dbz_flag", div_by_zero, 1'b1);
      check_output("dbz_busy", busy, 1'b0);
      check_output("dbz_stall", stall, 1'b0);
      check_output("dbz_hi", hi, m_hi);
      check_output("dbz_lo", lo, m_lo);
    end else begin
      edges = 1;
      stalls = 0;
      while (!done && edges < 100) begin
        if (stall) stalls++;
        @(negedge clk);
        edges++;
      end
      check_output("div_latency", edges, 34);
      check_output("div_stall_cycles", stalls, 32);
      check_output("div_hi", hi, m_hi);
      check_output("div_lo", lo, m_lo);
      check_output("div_busy_at_done", busy, 1'b0);
      check_output("div_no_dbz", div_by_zero, 1'b0);
    end
    @(negedge clk);
    check_output("div_done_pulse_end", done, 1'b0);
  endtask

  task automatic run_div8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int edges, stalls, sx, sy, q, r;
    logic [7:0] eq, er;
    if (o == OP_DIV) begin
      sx = int'($signed(x)); sy = int'($signed(y));
    end else begin
      sx = int'({24'd0, x}); sy = int'({24'd0, y});
    end
    q = sx / sy; r = sx % sy;
    eq = q[7:0]; er = r[7:0];
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0; op8 = OP_NOP;
    edges = 1; stalls = 0;
    while (!done8 && edges < 50) begin
      if (stall8) stalls++;
      @(negedge clk);
      edges++;
    end
    check_output("div8_latency", edges, 10);
    check_output("div8_stall_cycles", stalls, 8);
    check_output("div8_lo", lo8, eq);
    check_output("div8_hi", hi8, er);
    check_output("div8_no_dbz", dbz8, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [3:0]  ro;
    logic [31:0] rx, ry;
    int          done_seen, waited;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{OP_MTHI,  32'd0,         32'd0,        32'h0000_0000, 32'hFFFF_FFFA};
    vecs[3] = '{OP_MTLO,  32'd10,        32'd0,        32'h0000_0000, 32'h0000_000A};
    vecs[4] = '{OP_MADD,  32'd4,         32'd5,        32'h0000_0000, 32'h0000_001E};
    vecs[5] = '{OP_MSUBU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'h0000_001F};
    vecs[6] = '{OP_MSUB,  32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'h0000_0020};
    vecs[7] = '{OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0021};
    vecs[8] = '{4'd11,    32'h1234_5678, 32'd9,        32'hFFFF_FFFD, 32'h0000_0021};
    vecs[9] = '{OP_NOP,   32'h1234_5678, 32'd9,        32'hFFFF_FFFD, 32'h0000_0021};

    rst = 1'b0;
    start = 1'b0; op = OP_NOP; a = '0; b = '0;
    start8 = 1'b0; op8 = OP_NOP; a8 = '0; b8 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check_output("reset_hi", hi, 0);
    check_output("reset_lo", lo, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_dbz", div_by_zero, 0);
    check_output("reset_stall", stall, 0);
    check_output("reset8_busy", busy8, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      check_output($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check_output($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
    end

    run_div32(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_output("div_m7_by_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div32(OP_DIVU, 32'd100, 32'd7);
    check_output("divu_100_by_7", {hi, lo}, 64'h0000_0002_0000_000E);
    run_div32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_min_by_m1", {hi, lo}, 64'h0000_0000_8000_0000);

    apply_stimulus(OP_MTHI, 32'h11, 32'd0);
    apply_stimulus(OP_MTLO, 32'h22, 32'd0);
    run_div32(OP_DIVU, 32'h5555, 32'd0);
    check_output("dbz_preset", {hi, lo}, 64'h0000_0011_0000_0022);

    // Back-to-back: a new op issued in the very cycle done is high.
    start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    model_apply(OP_DIVU, 32'd50, 32'd5);
    waited = 0;
    while (!done && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_output("b2b_done_seen", done, 1'b1);
    apply_stimulus(OP_MTLO, 32'h1234, 32'd0);
    check_output("b2b_hi", hi, 32'd0);
    check_output("b2b_lo", lo, 32'h1234);

    // MTHI held during a divide is ignored; reset mid-RUN discards the divide.
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    @(negedge clk);
    op = OP_MTHI; a = 32'hDEAD;
    repeat (10) @(negedge clk);
    check_output("busy_mid_run", busy, 1'b1);
    check_output("mthi_ignored", hi, m_hi);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; op = OP_NOP;
    m_hi = '0; m_lo = '0;
    check_output("midrun_reset_hi", hi, 0);
    check_output("midrun_reset_lo", lo, 0);
    check_output("midrun_reset_busy", busy, 0);
    check_output("midrun_reset_stall", stall, 0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("midrun_reset_no_done", done_seen, 0);

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 12));
      rx = rand_operand();
      ry = rand_operand();
      if (ro == OP_DIV || ro == OP_DIVU) begin
        if ($urandom_range(0, 3) == 0) ry = 32'd0;
        run_div32(ro, rx, ry);
      end else begin
        apply_stimulus(ro, rx, ry);
        check_output($sformatf("rand%0d_hi", i), hi, m_hi);
        check_output($sformatf("rand%0d_lo", i), lo, m_lo);
      end
    end

    run_div8(OP_DIV, 8'h80, 8'hFF);
    check_output("div8_min_by_m1", {hi8, lo8}, 16'h0080);
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h7F; b8 = 8'h7F;
    #1;
    check_output("mul8_result", mul8, 16'h3F01);
    @(negedge clk);
    start8 = 1'b0; op8 = OP_NOP;
    check_output("mult8_hilo", {hi8, lo8}, 16'h3F01);
    for (int i = 0; i < 6; i++) begin
      rx = $urandom();
      ry = $urandom_range(1, 255);
      run_div8((i % 2 == 0) ? OP_DIV : OP_DIVU, rx[7:0], ry[7:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
